lighting_mode_ctrl: RTL and testbench
=====================================

// Module: lighting_mode_ctrl
//
// PURPOSE
//   Lamp/mode controller fed by the push-button classifier's pulse outputs.
//   Long-press pulse (A) toggles AUTO/MANUAL mode. Short-press pulse (B)
//   toggles the lamp in MANUAL mode. In AUTO mode the lamp follows a presence
//   sensor and stays on for a programmable hold time after presence is lost.
//   Drives the lamp driver and the mode indicator LED at the top level.
//
// PARAMETERS
//   AUTO_SHUTDOWN_T  30000  cycles lamp stays on in AUTO after last presence
//   CNT_W            16     hold-counter width; must satisfy 2**CNT_W > AUTO_SHUTDOWN_T
//
// PORTS
//   clk        in   1  clock
//   rst        in   1  reset, asynchronous, active-high
//   a_pulse    in   1  long-press event from button classifier (mode toggle)
//   b_pulse    in   1  short-press event from button classifier (lamp toggle)
//   presence   in   1  presence sensor, synchronous to clk, level
//   lamp       out  1  lamp enable
//   mode_auto  out  1  1 = AUTO mode, 0 = MANUAL mode
//
// BEHAVIOUR
//   - Reset: state AUTO_OFF, lamp=0, mode_auto=1, hold counter=0, edge regs=0.
//     rst mid-operation aborts immediately to this state; no pending event kept.
//   - a_pulse/b_pulse are rising-edge detected (a_ev = a_pulse & ~a_q); an input
//     held high for N cycles produces exactly one event.
//   - Moore outputs decoded from the state register: lamp=1 in AUTO_ON and
//     MANUAL_ON; mode_auto=1 in AUTO_OFF and AUTO_ON.
//   - Latency: an event or presence seen in cycle n changes outputs in cycle n+1.
//   - States / transitions (a_ev has priority over everything else):
//       AUTO_OFF   : a_ev -> MANUAL_OFF; else presence -> AUTO_ON
//       AUTO_ON    : a_ev -> MANUAL_ON; else !presence && cnt==AUTO_SHUTDOWN_T-1
//                    -> AUTO_OFF
//       MANUAL_OFF : a_ev -> AUTO_OFF; else b_ev -> MANUAL_ON
//       MANUAL_ON  : a_ev -> AUTO_ON (hold counter starts fresh); else b_ev
//                    -> MANUAL_OFF
//   - Hold counter: clears to 0 when presence=1 or state != AUTO_ON; otherwise
//     increments by 1. Never exceeds AUTO_SHUTDOWN_T-1; no wrap-around.
//     Result: last presence-high cycle k -> lamp=1 through cycle k+AUTO_SHUTDOWN_T,
//     lamp=0 from cycle k+AUTO_SHUTDOWN_T+1.
//   - Presence re-asserted during the hold clears cnt; lamp stays on, no glitch.
//   - b_ev ignored in AUTO states; presence ignored in MANUAL states.
//   - a_ev and b_ev in the same cycle: mode toggles, b_ev discarded.
//   - Mode toggle preserves the lamp level (ON<->ON, OFF<->OFF).
//
// STRUCTURE
//   - lighting_pkg: state_t enum {AUTO_OFF, AUTO_ON, MANUAL_OFF, MANUAL_ON}
//     (logic [1:0]); default AUTO_SHUTDOWN_T constant shared with top level.
//   - Sub-module edge_pulse (1-bit rising-edge detector, async rst), instanced
//     twice (A and B). FSM, hold counter and output decode stay in this module.
//
// TESTING  (bench uses AUTO_SHUTDOWN_T=10, CNT_W=4)
//   - Reset release, no stimulus 50 cycles -> lamp=0, mode_auto=1 throughout.
//   - AUTO: presence=1 cycles 5..7 -> lamp=1 from cycle 6, lamp=1 through 17,
//     lamp=0 at cycle 18.
//   - AUTO hold: presence=1 @5, re-pulse @12 -> lamp stays 1, falls at cycle 23.
//   - a_pulse one cycle @5 -> mode_auto=0 @6; b_pulse @10 -> lamp=1 @11;
//     b_pulse held 8 cycles @20 -> lamp=0 @21, no further toggles.
//   - MANUAL_ON, a_pulse and b_pulse together @30 -> mode_auto=1, lamp=1 @31,
//     presence=0 -> lamp=0 @41.
//   - rst asserted mid-hold (cnt=5) -> lamp=0, mode_auto=1 immediately
//     (async, same cycle), cnt=0 after release.

Source files
------------

// File: rtl/lighting_pkg.sv
// Shared types and defaults for the lamp/mode controller.
package lighting_pkg;

  typedef enum logic [1:0] {
    AUTO_OFF   = 2'd0,
    AUTO_ON    = 2'd1,
    MANUAL_OFF = 2'd2,
    MANUAL_ON  = 2'd3
  } state_t;

  localparam int DEFAULT_AUTO_SHUTDOWN_T = 30000;
  localparam int DEFAULT_CNT_W           = 16;

endpackage

// File: rtl/edge_pulse.sv
// One-bit rising-edge detector: a level held high yields a single-cycle event.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic ev
);

  logic q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= 1'b0;
    end else begin
      q_reg <= din;
    end
  end

  assign ev = din & ~q_reg;

endmodule

// File: rtl/lighting_mode_ctrl.sv
// Lamp/mode controller: long press toggles AUTO/MANUAL, short press toggles the
// lamp in MANUAL, AUTO follows presence with a hold-off timer.
module lighting_mode_ctrl
  import lighting_pkg::*;
#(
  parameter int AUTO_SHUTDOWN_T = DEFAULT_AUTO_SHUTDOWN_T,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic a_pulse,
  input  logic b_pulse,
  input  logic presence,
  output logic lamp,
  output logic mode_auto
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_SHUTDOWN_T - 1);

  logic             a_ev;
  logic             b_ev;
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  edge_pulse u_edge_a (
    .clk (clk),
    .rst (rst),
    .din (a_pulse),
    .ev  (a_ev)
  );

  edge_pulse u_edge_b (
    .clk (clk),
    .rst (rst),
    .din (b_pulse),
    .ev  (b_ev)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= AUTO_OFF;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Mode event wins over everything; a toggle keeps the lamp level.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      AUTO_OFF: begin
        if (a_ev)          state_next = MANUAL_OFF;
        else if (presence) state_next = AUTO_ON;
      end
      AUTO_ON: begin
        if (a_ev)                                state_next = MANUAL_ON;
        else if (!presence && cnt_reg == CNT_LAST) state_next = AUTO_OFF;
      end
      MANUAL_OFF: begin
        if (a_ev)      state_next = AUTO_OFF;
        else if (b_ev) state_next = MANUAL_ON;
      end
      MANUAL_ON: begin
        if (a_ev)      state_next = AUTO_ON;
        else if (b_ev) state_next = MANUAL_OFF;
      end
      default: state_next = AUTO_OFF;
    endcase
  end

  // Hold counter saturates at the last hold cycle; the FSM leaves AUTO_ON there.
  always_comb begin
    cnt_next = cnt_reg;
    if (presence || state_reg != AUTO_ON) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_LAST) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign lamp      = (state_reg == AUTO_ON)  || (state_reg == MANUAL_ON);
  assign mode_auto = (state_reg == AUTO_OFF) || (state_reg == AUTO_ON);

endmodule

// File: tb/tb_lighting_mode_ctrl.sv
// Directed bench for lighting_mode_ctrl with a 10-cycle hold time.
module tb_lighting_mode_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic a_pulse;
  logic b_pulse;
  logic presence;
  logic lamp;
  logic mode_auto;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  lighting_mode_ctrl #(
    .AUTO_SHUTDOWN_T (10),
    .CNT_W           (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_pulse   (a_pulse),
    .b_pulse   (b_pulse),
    .presence  (presence),
    .lamp      (lamp),
    .mode_auto (mode_auto)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  // Leaves the bench 1ns after a posedge with reset released: that is cycle 0.
  task automatic do_reset();
    rst      = 1'b1;
    a_pulse  = 1'b0;
    b_pulse  = 1'b0;
    presence = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_lamp", lamp, 1'b0);
    check_bit("rst_mode", mode_auto, 1'b1);
    rst = 1'b0;
  endtask

  // Inputs for cycle c are set at posedge+1, outputs sampled at negedge.
  task automatic sample(input string tag, input int c, input logic exp_lamp,
                        input logic exp_mode);
    #4;
    check_bit($sformatf("%s_lamp_c%0d", tag, c), lamp, exp_lamp);
    check_bit($sformatf("%s_mode_c%0d", tag, c), mode_auto, exp_mode);
    $display("%s cycle %0d: lamp=%b mode_auto=%b", tag, c, lamp, mode_auto);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Idle after reset: AUTO, lamp off.
    do_reset();
    for (int c = 0; c < 50; c++) sample("idle", c, 1'b0, 1'b1);

    // Presence 5..7, lamp on 6..17.
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      presence = (c >= 5 && c <= 7);
      sample("auto", c, (c >= 6 && c <= 17), 1'b1);
    end

    // Presence 5 and re-pulse at 12: lamp on 6..22, off at 23.
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      presence = (c == 5 || c == 12);
      sample("hold", c, (c >= 6 && c <= 22), 1'b1);
    end

    // MANUAL: a@5, b@10, b held 20..27, presence ignored 33..36.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      a_pulse  = (c == 5);
      b_pulse  = (c == 10) || (c >= 20 && c <= 27);
      presence = (c >= 33 && c <= 36);
      sample("manual", c, (c >= 11 && c <= 20), (c <= 5));
    end

    // MANUAL_ON then a+b together @30: AUTO_ON, hold to 40, b@44 ignored.
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      a_pulse = (c == 5) || (c == 30);
      b_pulse = (c == 10) || (c == 30) || (c == 44);
      sample("ab", c, (c >= 11 && c <= 40), (c <= 5) || (c >= 31));
    end

    // Async reset mid-hold (cnt=5 in cycle 6), then a fresh hold.
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      presence = (c == 0);
      sample("prerst", c, (c >= 1), 1'b1);
    end
    #1;
    rst = 1'b1;
    #1;
    check_bit("async_rst_lamp", lamp, 1'b0);
    check_bit("async_rst_mode", mode_auto, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      presence = (c == 2);
      sample("postrst", c, (c >= 3 && c <= 12), 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
